// File: rtl/scoreboard_tracker_pkg.sv
// Shared types and sizing for the register scoreboard tracker.
package scoreboard_tracker_pkg;

   localparam int unsigned SB_NUM_REGS = 32;
   localparam int unsigned SB_RD_W     = 5;
   localparam int unsigned SB_CNT_W    = 2;

   typedef struct packed {
      logic              valid;
      logic [SB_RD_W-1:0] rd;
   } sb_event_t;

   typedef logic [SB_CNT_W-1:0] sb_cnt_t;

endpackage

// File: rtl/scoreboard_tracker_if.sv
// Issue, writeback and squash events in; scoreboard status out.
interface scoreboard_tracker_if;
   import scoreboard_tracker_pkg::*;

   logic                   iss_a_valid;
   logic [SB_RD_W-1:0]     iss_a_rd;
   logic                   iss_b_valid;
   logic [SB_RD_W-1:0]     iss_b_rd;
   logic                   wb_a_valid;
   logic [SB_RD_W-1:0]     wb_a_rd;
   logic                   wb_b_valid;
   logic [SB_RD_W-1:0]     wb_b_rd;
   logic                   kill_a_valid;
   logic [SB_RD_W-1:0]     kill_a_rd;
   logic                   kill_b_valid;
   logic [SB_RD_W-1:0]     kill_b_rd;
   logic [SB_NUM_REGS-1:0] scoreboard;
   logic [SB_NUM_REGS-1:0] sat;
   logic                   idle;
   logic                   err;

   modport master (
      output iss_a_valid, iss_a_rd, iss_b_valid, iss_b_rd,
      output wb_a_valid, wb_a_rd, wb_b_valid, wb_b_rd,
      output kill_a_valid, kill_a_rd, kill_b_valid, kill_b_rd,
      input  scoreboard, sat, idle, err
   );

   modport slave (
      input  iss_a_valid, iss_a_rd, iss_b_valid, iss_b_rd,
      input  wb_a_valid, wb_a_rd, wb_b_valid, wb_b_rd,
      input  kill_a_valid, kill_a_rd, kill_b_valid, kill_b_rd,
      output scoreboard, sat, idle, err
   );

endinterface

// File: rtl/scoreboard_tracker_sb_reg_counter.sv
// Saturating in-flight writer counter for one architectural register.
module sb_reg_counter
   import scoreboard_tracker_pkg::*;
#(
   parameter int unsigned CNT_W = SB_CNT_W
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_inc,
   input  logic [2:0] i_dec,
   output logic       o_busy,
   output logic       o_sat,
   output logic       o_ovf,
   output logic       o_unf
);

   localparam int unsigned W = CNT_W + 3;
   localparam logic signed [W-1:0] MaxCnt = W'((2 ** CNT_W) - 1);

   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_d;
   logic signed [W-1:0]   w_next;

   always_comb begin
      // Issue and retire in the same cycle net out before clamping.
      w_next  = $signed(W'(r_cnt)) + $signed(W'(i_inc)) - $signed(W'(i_dec));
      o_ovf   = w_next > MaxCnt;
      o_unf   = w_next[W-1];
      w_cnt_d = w_next[CNT_W-1:0];
      if (o_ovf) begin
         w_cnt_d = '1;
      end else if (o_unf) begin
         w_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_d;
      end
   end

   assign o_busy = |r_cnt;
   assign o_sat  = &r_cnt;

endmodule

// File: rtl/scoreboard_tracker.sv
// Per-register in-flight writer tracking for the dual-issue hazard unit.
module scoreboard_tracker
   import scoreboard_tracker_pkg::*;
#(
   parameter int unsigned NUM_REGS = SB_NUM_REGS,
   parameter int unsigned CNT_W    = SB_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   scoreboard_tracker_if.slave   io_sb
);

   sb_event_t           w_iss [2];
   sb_event_t           w_ret [4];
   logic [NUM_REGS-1:0] w_busy;
   logic [NUM_REGS-1:0] w_sat;
   logic [NUM_REGS-1:0] w_ovf;
   logic [NUM_REGS-1:0] w_unf;
   logic                r_err;

   assign w_iss[0] = {io_sb.iss_a_valid, io_sb.iss_a_rd};
   assign w_iss[1] = {io_sb.iss_b_valid, io_sb.iss_b_rd};
   assign w_ret[0] = {io_sb.wb_a_valid, io_sb.wb_a_rd};
   assign w_ret[1] = {io_sb.wb_b_valid, io_sb.wb_b_rd};
   assign w_ret[2] = {io_sb.kill_a_valid, io_sb.kill_a_rd};
   assign w_ret[3] = {io_sb.kill_b_valid, io_sb.kill_b_rd};

   // x0 has no counter, so rd==0 events fall through unmatched.
   assign w_busy[0] = 1'b0;
   assign w_sat[0]  = 1'b0;
   assign w_ovf[0]  = 1'b0;
   assign w_unf[0]  = 1'b0;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
      logic [1:0] w_inc;
      logic [2:0] w_dec;

      always_comb begin
         w_inc = '0;
         w_dec = '0;
         for (int i = 0; i < 2; i++) begin
            if (w_iss[i].valid && w_iss[i].rd == SB_RD_W'(r)) w_inc = w_inc + 2'd1;
         end
         for (int i = 0; i < 4; i++) begin
            if (w_ret[i].valid && w_ret[i].rd == SB_RD_W'(r)) w_dec = w_dec + 3'd1;
         end
      end

      sb_reg_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_inc  (w_inc),
         .i_dec  (w_dec),
         .o_busy (w_busy[r]),
         .o_sat  (w_sat[r]),
         .o_ovf  (w_ovf[r]),
         .o_unf  (w_unf[r])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else begin
         r_err <= r_err | (|w_ovf) | (|w_unf);
      end
   end

   assign io_sb.scoreboard = w_busy;
   assign io_sb.sat        = w_sat;
   assign io_sb.idle       = ~|w_busy;
   assign io_sb.err        = r_err;

endmodule

// File: doc/scoreboard_tracker.md
Name: scoreboard_tracker

Overview:
- Owns the 32-bit register scoreboard that the dual-issue hazard/issue logic reads each cycle.
- Marks destination registers pending when slot A and/or slot B issue a register-writing op, and releases them on writeback from either datapath or on squash of an in-flight op.
- Keeps a per-register in-flight counter, not a single bit, so that WAW sequences (two writes to the same rd in flight) release only after the last writer retires.
- Sits between the issue stage (producer of issue events) and the two writeback ports (consumers).

Parameters:
- NUM_REGS, 32, architectural integer registers tracked; x0 is never tracked.
- CNT_W, 2, width of each in-flight counter; maximum in-flight writers per register = 2**CNT_W-1 (3).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- iss_a_valid  in  1  slot A issued this cycle and writes a register
- iss_a_rd  in  5  slot A destination
- iss_b_valid  in  1  slot B issued this cycle and writes a register
- iss_b_rd  in  5  slot B destination
- wb_a_valid  in  1  datapath A retiring a register write
- wb_a_rd  in  5  datapath A destination
- wb_b_valid  in  1  datapath B retiring a register write
- wb_b_rd  in  5  datapath B destination
- kill_a_valid  in  1  in-flight slot-A op squashed (no writeback will follow)
- kill_a_rd  in  5  its destination
- kill_b_valid  in  1  in-flight slot-B op squashed
- kill_b_rd  in  5  its destination
- scoreboard  out  32  bit r = counter[r] != 0; bit 0 always 0
- sat  out  32  bit r = counter[r] at maximum; the issue stage must not issue another writer of r
- idle  out  1  all counters zero
- err  out  1  sticky protocol-error flag

Behaviour:
- State: counter[1..NUM_REGS-1], CNT_W bits each, plus the sticky err register. All outputs are decoded combinationally from registered state, so an update is visible the cycle after the event.
- Reset (async, rst_n=0): all counters 0, err=0. Resulting outputs: scoreboard=0, sat=0, idle=1.
- Per cycle, per register r≠0:
  - inc = (iss_a_valid && iss_a_rd==r) + (iss_b_valid && iss_b_rd==r), range 0..2.
  - dec = matching wb_a + wb_b + kill_a + kill_b, range 0..4.
  - next = counter + inc - dec, computed in a signed (CNT_W+3)-bit intermediate.
- Events whose rd==0 are ignored entirely and never raise err.
- Simultaneous issue and writeback to the same register in the same cycle are netted. Example: counter=1, issue+wb to r → stays 1, scoreboard[r] stays 1.
- Both slots issuing the same rd in one cycle → +2.
- Overflow: if next > max, clamp to max and set err.
- Underflow: if next < 0, clamp to 0 and set err.
- err clears only on reset.
- Writeback of a register in cycle N clears scoreboard[r] at cycle N+1 (when the count reaches 0). There is no same-cycle bypass; the hazard unit sees the register as busy during cycle N, which is conservative.
- sat[r] = (counter[r] == 2**CNT_W-1).
- idle = no counter nonzero. It is asserted for pipeline drain before fence/CSR ops.
- Reset asserted mid-operation: all state clears immediately. In-flight writebacks arriving after reset release are underflows and set err; the pipeline is required to be flushed by the same reset.
- No handshake back-pressure: every valid event is consumed in the cycle presented.

Decomposition:
- core_types_pkg gains:
  - localparam SB_CNT_W
  - typedef sb_event_t {logic valid; logic [4:0] rd;}
  - typedef sb_cnt_t
- Port groups may be carried as sb_event_t.
- One natural sub-module, sb_reg_counter: one per register; inputs inc[1:0], dec[2:0]; outputs busy, sat, ovf, unf. Generated for r=1..31.

Test Plan:
1. Reset with rst_n=0 mid-traffic (counters nonzero) → scoreboard=0, sat=0, idle=1, err=0 immediately (asynchronous).
2. iss_a rd=5 in cycle 0; wb_a rd=5 in cycle 3 → scoreboard[5]=1 in cycles 1-3, 0 from cycle 4; idle returns to 1 at cycle 4.
3. WAW sequence:
   - iss_a rd=7 and iss_b rd=7 in the same cycle → counter 2.
   - wb_a rd=7 → scoreboard[7] stays 1.
   - wb_b rd=7 the next cycle → scoreboard[7] drops to 0.
4. Counter[9]=1; same cycle iss_b rd=9 and wb_a rd=9 → counter stays 1, scoreboard[9]=1, err=0. Separately, iss_a rd=0 with wb_b rd=0 → no change, err=0.
5. Saturation and overflow:
   - Three issues to rd=12 → sat[12]=1.
   - A fourth issue → counter stays 3, err=1.
   - Three writebacks → scoreboard[12]=0; err remains 1.
6. Squash and underflow:
   - iss_a rd=3, then kill_a rd=3 → scoreboard[3] clears next cycle.
   - Additional wb_b rd=3 with count 0 → counter stays 0, err=1.
